// File: rtl/switch_debounce4.sv
// switch_debounce4 -- input conditioning for the gates4 block.
//
// Synchronises WIDTH raw switch/button levels to clk through a two-flop
// chain, debounces each bit on its own, and presents a clean bus plus
// one-cycle edge pulses.
//
// Optional build macro: SWITCH_DEBOUNCE4_BYPASS_EN
//   undefined : full per-bit debounce (a level must hold CNT_MAX cycles)
//   defined   : counters and FSM removed, sw_out follows the synchroniser;
//               only for simulation speed and lab bring-up
//
// Parameters
//   WIDTH    number of independent input bits (default 4 = gates4 width)
//   CNT_MAX  stable cycles needed before an output bit changes (>= 2)
//
// Ports
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   sw_in    raw asynchronous switch levels
//   sw_out   debounced level bus, feeds gates4.in
//   sw_rise  one-cycle pulse per bit on a debounced 0->1 change
//   sw_fall  one-cycle pulse per bit on a debounced 1->0 change
//   changed  OR of all sw_rise | sw_fall bits, aligned with them

// ---------------------------------------------------------------------------
// Per-bit debounce lane. sync_bit is already synchronised to clk.
// evt_nxt is the unregistered "a pulse is being launched" flag, used by the
// top to build a registered changed strobe in the same cycle as the pulses.
// ---------------------------------------------------------------------------
module switch_debounce4_lane #(
  parameter int CNT_MAX = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_bit,
  output logic q,
  output logic rise,
  output logic fall,
  output logic evt_nxt
);

`ifdef SWITCH_DEBOUNCE4_BYPASS_EN

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      q    <= sync_bit;
      rise <= sync_bit & ~q;
      fall <= ~sync_bit & q;
    end
  end

  assign evt_nxt = sync_bit ^ q;

`else

  localparam int CW = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } st_t;

  st_t           st, st_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          q_nxt, rise_nxt, fall_nxt;
  logic          diff, done;

  // diff: synchronised level disagrees with the debounced output.
  // done: it has disagreed for CNT_MAX consecutive evaluations.
  assign diff = sync_bit ^ q;
  assign done = diff && (st == CHECK) && (cnt == CNT_LAST);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= IDLE;
      cnt  <= '0;
      q    <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      st   <= st_nxt;
      cnt  <= cnt_nxt;
      q    <= q_nxt;
      rise <= rise_nxt;
      fall <= fall_nxt;
    end
  end

  // next state: any agreement (or a completed count) returns to IDLE, which
  // is what throws away a bounce shorter than CNT_MAX cycles
  always_comb begin
    st_nxt = st;
    if (!diff || done) st_nxt = IDLE;
    else               st_nxt = CHECK;
  end

  // outputs / datapath. In IDLE the counter is known to be 0, so entering
  // CHECK loads 1 directly.
  always_comb begin
    cnt_nxt  = '0;
    q_nxt    = q;
    rise_nxt = 1'b0;
    fall_nxt = 1'b0;
    if (done) begin
      q_nxt    = sync_bit;
      rise_nxt = sync_bit;
      fall_nxt = ~sync_bit;
    end else if (diff) begin
      cnt_nxt = (st == CHECK) ? cnt + CW'(1) : CW'(1);
    end
  end

  assign evt_nxt = rise_nxt | fall_nxt;

`endif

endmodule

// ---------------------------------------------------------------------------
// Top: synchroniser chain, lane array, registered changed strobe.
// ---------------------------------------------------------------------------
module switch_debounce4 #(
  parameter int WIDTH   = 4,
  parameter int CNT_MAX = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             changed
);

  logic [WIDTH-1:0] sync1, sync2;
  logic [WIDTH-1:0] evt_nxt;

  // two-flop synchroniser; sw_in is asynchronous to clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_in;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    switch_debounce4_lane #(
      .CNT_MAX (CNT_MAX)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .sync_bit(sync2[i]),
      .q       (sw_out[i]),
      .rise    (sw_rise[i]),
      .fall    (sw_fall[i]),
      .evt_nxt (evt_nxt[i])
    );
  end

  // built from the lanes' next-cycle pulses so it lands with sw_rise/sw_fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) changed <= 1'b0;
    else        changed <= |evt_nxt;
  end

endmodule

// File: tb/tb_switch_debounce4.sv
module tb_switch_debounce4;
  localparam int WIDTH   = 4;
  localparam int CNT_MAX = 4;
`ifdef SWITCH_DEBOUNCE4_BYPASS_EN
  localparam int LAT = 3;
`else
  localparam int LAT = CNT_MAX + 2;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] sw_in;
  logic [WIDTH-1:0] sw_out, sw_rise, sw_fall;
  logic             changed;

  always #5 clk = ~clk;

  switch_debounce4 #(.WIDTH(WIDTH), .CNT_MAX(CNT_MAX)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw_in  (sw_in),
    .sw_out (sw_out),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall),
    .changed(changed)
  );

  typedef struct packed {
    logic [3:0] out;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       chg;
  } obs_t;

  obs_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [3:0] m_s1 = '0, m_s2 = '0, m_out = '0;
  int         m_cnt[4];

  function automatic obs_t dut_obs();
    return {sw_out, sw_rise, sw_fall, changed};
  endfunction

  // behavioural model: evaluated on each rising edge, expected outputs queued
  task automatic model_step();
    obs_t e;
    e = '0;
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_out = '0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else begin
`ifdef SWITCH_DEBOUNCE4_BYPASS_EN
      e.rise = m_s2 & ~m_out;
      e.fall = ~m_s2 & m_out;
      m_out  = m_s2;
`else
      for (int i = 0; i < 4; i++) begin
        if (m_s2[i] == m_out[i]) m_cnt[i] = 0;
        else if (m_cnt[i] == CNT_MAX - 1) begin
          m_out[i]  = m_s2[i];
          m_cnt[i]  = 0;
          e.rise[i] = m_s2[i];
          e.fall[i] = ~m_s2[i];
        end else m_cnt[i]++;
      end
`endif
      m_s2 = m_s1;
      m_s1 = sw_in;
    end
    e.out = m_out;
    e.chg = |(e.rise | e.fall);
    sb.push_back(e);
  endtask

  // drive at the falling edge, step model on the rising edge, return at the
  // next falling edge so outputs are sampled mid-cycle
  task automatic cycle(input logic [3:0] v);
    sw_in = v;
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    obs_t e;
    rst_n = 1'b1;
    sw_in = 4'hF;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (dut_obs() !== '0) begin
      failures++; $display("FAIL reset_async got=%h exp=0", dut_obs());
    end
    @(negedge clk);
    repeat (3) begin
      cycle(4'hF);
      e = sb.pop_front(); checks++;
      if (dut_obs() !== e) begin
        failures++; $display("FAIL reset_hold cyc=%0d got=%h exp=%h", cyc, dut_obs(), e);
      end
    end
    rst_n = 1'b1;
    for (int k = 1; k <= LAT + 2; k++) begin
      cycle(4'hF);
      e = sb.pop_front(); checks++;
      if (dut_obs() !== e) begin
        failures++; $display("FAIL reset_sb k=%0d got=%h exp=%h", k, dut_obs(), e);
      end
      if (k == LAT - 1) begin
        checks++;
        if ({sw_out, changed} !== 5'b0) begin
          failures++; $display("FAIL release_early k=%0d out=%b chg=%b exp=0", k, sw_out, changed);
        end
      end
      if (k == LAT) begin
        checks++;
        if ({sw_out, sw_rise, sw_fall, changed} !== {4'hF, 4'hF, 4'h0, 1'b1}) begin
          failures++;
          $display("FAIL release_rise out=%b rise=%b fall=%b chg=%b exp=1111/1111/0000/1",
                   sw_out, sw_rise, sw_fall, changed);
        end
      end
      if (k == LAT + 1) begin
        checks++;
        if ({sw_rise, changed} !== 5'b0) begin
          failures++; $display("FAIL release_pulse_len rise=%b chg=%b exp=0", sw_rise, changed);
        end
      end
    end
  endtask

  task automatic test_multi_fall();
    obs_t e;
    int   nchg;
    nchg = 0;
    for (int k = 1; k <= LAT + 3; k++) begin
      cycle(4'hA);
      e = sb.pop_front(); checks++;
      if (dut_obs() !== e) begin
        failures++; $display("FAIL mfall_sb k=%0d got=%h exp=%h", k, dut_obs(), e);
      end
      if (changed) nchg++;
      if (k == LAT) begin
        checks++;
        if ({sw_out, sw_rise, sw_fall} !== {4'hA, 4'h0, 4'h5}) begin
          failures++;
          $display("FAIL mfall_edge out=%b rise=%b fall=%b exp=1010/0000/0101", sw_out, sw_rise, sw_fall);
        end
      end
    end
    checks++;
    if (nchg !== 1) begin
      failures++; $display("FAIL mfall_chg_count got=%0d exp=1", nchg);
    end
  endtask

  task automatic test_reset_mid_count();
    obs_t e;
    repeat (2) begin
      cycle(4'h6);
      e = sb.pop_front(); checks++;
      if (dut_obs() !== e) begin
        failures++; $display("FAIL midrst_pre got=%h exp=%h", dut_obs(), e);
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (dut_obs() !== '0) begin
      failures++; $display("FAIL midrst_force got=%h exp=0", dut_obs());
    end
    cycle(4'h6);
    e = sb.pop_front(); checks++;
    if (dut_obs() !== e) begin
      failures++; $display("FAIL midrst_hold got=%h exp=%h", dut_obs(), e);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= LAT + 1; k++) begin
      cycle(4'h6);
      e = sb.pop_front(); checks++;
      if (dut_obs() !== e) begin
        failures++; $display("FAIL midrst_sb k=%0d got=%h exp=%h", k, dut_obs(), e);
      end
      if (k == LAT - 1) begin
        checks++;
        if (sw_out !== 4'h0) begin
          failures++; $display("FAIL midrst_early out=%b exp=0000", sw_out);
        end
      end
      if (k == LAT) begin
        checks++;
        if ({sw_out, sw_rise} !== {4'h6, 4'h6}) begin
          failures++; $display("FAIL midrst_restart out=%b rise=%b exp=0110/0110", sw_out, sw_rise);
        end
      end
    end
  endtask

  task automatic test_single_rise();
    obs_t e;
    repeat (LAT + 2) begin
      cycle(4'h0);
      e = sb.pop_front(); checks++;
      if (dut_obs() !== e) begin
        failures++; $display("FAIL clear_sb got=%h exp=%h", dut_obs(), e);
      end
    end
    for (int k = 1; k <= 10; k++) begin
      cycle(4'h1);
      e = sb.pop_front(); checks++;
      if (dut_obs() !== e) begin
        failures++; $display("FAIL rise0_sb k=%0d got=%h exp=%h", k, dut_obs(), e);
      end
      if (k == LAT) begin
        checks++;
        if ({sw_out, sw_rise, sw_fall} !== {4'h1, 4'h1, 4'h0}) begin
          failures++;
          $display("FAIL rise0_edge out=%b rise=%b fall=%b exp=0001/0001/0000", sw_out, sw_rise, sw_fall);
        end
      end
    end
    checks++;
    if ({&sw_out, |sw_out, ^sw_out} !== 3'b011) begin
      failures++; $display("FAIL gates_view and/or/xor=%b exp=011", {&sw_out, |sw_out, ^sw_out});
    end
  endtask

  task automatic test_bounce();
    obs_t       e;
    logic [7:0] pat;
    logic       b;
    int         nrise, last;
`ifdef SWITCH_DEBOUNCE4_BYPASS_EN
    localparam int NRISE = 3;
`else
    localparam int NRISE = 1;
`endif
    pat   = 8'b0011_0011;  // bit i = value driven in cycle i
    nrise = 0;
    last  = 0;
    for (int k = 0; k < 20; k++) begin
      b = (k < 8) ? pat[k] : 1'b1;
      cycle({1'b0, b, 2'b01});
      e = sb.pop_front(); checks++;
      if (dut_obs() !== e) begin
        failures++; $display("FAIL bounce_sb k=%0d got=%h exp=%h", k, dut_obs(), e);
      end
      if (sw_rise[2]) begin nrise++; last = k + 1; end
    end
    checks++;
    if (nrise !== NRISE) begin
      failures++; $display("FAIL bounce_count got=%0d exp=%0d", nrise, NRISE);
    end
    checks++;
    if (last !== 9 + LAT - 1) begin
      failures++; $display("FAIL bounce_latency got=%0d exp=%0d", last, 9 + LAT - 1);
    end
  endtask

  task automatic test_steady();
    obs_t e;
    int   nchg;
    nchg = 0;
    repeat (20) begin
      cycle(4'h5);
      e = sb.pop_front(); checks++;
      if (dut_obs() !== e) begin
        failures++; $display("FAIL steady_sb got=%h exp=%h", dut_obs(), e);
      end
      if (changed) nchg++;
    end
    checks++;
    if (nchg !== 0 || sw_out !== 4'h5) begin
      failures++; $display("FAIL steady pulses=%0d out=%b exp=0/0101", nchg, sw_out);
    end
  endtask

  task automatic test_glitch();
    obs_t e;
    int   nr, nf;
`ifdef SWITCH_DEBOUNCE4_BYPASS_EN
    localparam int NP = 1;
`else
    localparam int NP = 0;
`endif
    nr = 0;
    nf = 0;
    for (int k = 0; k < 10; k++) begin
      cycle((k == 0) ? 4'hD : 4'h5);
      e = sb.pop_front(); checks++;
      if (dut_obs() !== e) begin
        failures++; $display("FAIL glitch_sb k=%0d got=%h exp=%h", k, dut_obs(), e);
      end
      if (sw_rise[3]) nr++;
      if (sw_fall[3]) nf++;
    end
    checks++;
    if (nr !== NP || nf !== NP || sw_out !== 4'h5) begin
      failures++;
      $display("FAIL glitch rise3=%0d fall3=%0d out=%b exp=%0d/%0d/0101", nr, nf, sw_out, NP, NP);
    end
  endtask

  initial begin
    test_reset();
    test_multi_fall();
    test_reset_mid_count();
    test_single_rise();
    test_bounce();
    test_steady();
    test_glitch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
